// File: rtl/icache_pkg.sv
// icache_pkg: shared definitions for the instruction cache.
//   - Default bus widths (address / instruction) and cache geometry.
//   - Controller state encoding used by the top-level FSM.
package icache_pkg;

  localparam int ADDR_BUS_W   = 32;
  localparam int INST_BUS_W   = 32;
  localparam int ICACHE_LINES = 16;
  localparam int ICACHE_WORDS = 4;

  typedef enum logic {
    ICACHE_IDLE   = 1'b0,
    ICACHE_REFILL = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache_store.sv
// icache_store: tag, valid and data arrays of the direct-mapped icache.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset (valid bits only)
//   rd_index_i, rd_offset_i  combinational read address
//   rd_tag_o, rd_valid_o,    tag, valid bit and data word at the read address
//   rd_data_o
//   word_we_i, wr_index_i,   synchronous single-word write
//   wr_offset_i, wr_data_i
//   tag_we_i, wr_tag_i,      synchronous tag + valid write for line wr_index_i
//   wr_valid_i
//   clear_i                  synchronous clear of every valid bit
module icache_store
  import icache_pkg::*;
#(
  parameter int ADDR_W = ADDR_BUS_W,
  parameter int DATA_W = INST_BUS_W,
  parameter int LINES  = ICACHE_LINES,
  parameter int WORDS  = ICACHE_WORDS,
  localparam int OFF_W = $clog2(WORDS),
  localparam int IDX_W = $clog2(LINES),
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_index_i,
  input  logic [OFF_W-1:0]  rd_offset_i,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              word_we_i,
  input  logic [IDX_W-1:0]  wr_index_i,
  input  logic [OFF_W-1:0]  wr_offset_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              tag_we_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic              wr_valid_i,
  input  logic              clear_i
);

  logic [DATA_W-1:0] data_mem [LINES][WORDS];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  valid_d;

  assign rd_tag_o   = tag_mem[rd_index_i];
  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_data_o  = data_mem[rd_index_i][rd_offset_i];

  // A clear-all beats a concurrent line install, so a fence.i landing on
  // the final refill beat never leaves that line valid.
  always_comb begin
    valid_d = valid_q;
    if (clear_i) begin
      valid_d = '0;
    end else if (tag_we_i) begin
      valid_d[wr_index_i] = wr_valid_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (word_we_i) begin
      data_mem[wr_index_i][wr_offset_i] <= wr_data_i;
    end
    if (tag_we_i) begin
      tag_mem[wr_index_i] <= wr_tag_i;
    end
  end

endmodule

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache with line refill.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   req_valid_i     fetch request from the PC stage
//   addr_i          fetch byte address (bits [1:0] ignored)
//   wen_i           write flag; write requests are dropped
//   invalidate_i    clear all valid bits (fence.i)
//   data_o          returned instruction (registered)
//   data_valid_o    data_o valid this cycle
//   mem_req_o       backing-memory word read request
//   mem_addr_o      word-aligned backing-memory address
//   mem_valid_i     one-cycle pulse, mem_data_i valid
//   mem_data_i      backing-memory read data
module icache
  import icache_pkg::*;
#(
  parameter int ADDR_W = ADDR_BUS_W,
  parameter int DATA_W = INST_BUS_W,
  parameter int LINES  = ICACHE_LINES,
  parameter int WORDS  = ICACHE_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              wen_i,
  input  logic              invalidate_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_valid_i,
  input  logic [DATA_W-1:0] mem_data_i
);

  localparam int OFF_W  = $clog2(WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W - 2;
  localparam int LINE_W = TAG_W + IDX_W;

  icache_state_e     state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic              kill_q, kill_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              data_valid_q, data_valid_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              word_we;
  logic              tag_we;
  logic              wr_valid;
  logic              hit;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^addr_i[1:0];

  icache_store #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LINES  (LINES),
    .WORDS  (WORDS)
  ) u_store (
    .clk         (clk),
    .rst         (rst),
    .rd_index_i  (addr_i[IDX_W+OFF_W+1:OFF_W+2]),
    .rd_offset_i (addr_i[OFF_W+1:2]),
    .rd_tag_o    (rd_tag),
    .rd_valid_o  (rd_valid),
    .rd_data_o   (rd_data),
    .word_we_i   (word_we),
    .wr_index_i  (line_q[IDX_W-1:0]),
    .wr_offset_i (cnt_q),
    .wr_data_i   (mem_data_i),
    .tag_we_i    (tag_we),
    .wr_tag_i    (line_q[LINE_W-1:IDX_W]),
    .wr_valid_i  (wr_valid),
    .clear_i     (invalidate_i)
  );

  // Lookup sees the array state before any same-cycle invalidate.
  assign hit = rd_valid && (rd_tag == addr_i[ADDR_W-1:IDX_W+OFF_W+2]);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    kill_d       = kill_q;
    line_d       = line_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    word_we      = 1'b0;
    tag_we       = 1'b0;
    wr_valid     = 1'b0;

    unique case (state_q)
      ICACHE_IDLE: begin
        kill_d = 1'b0;
        if (req_valid_i && !wen_i) begin
          if (hit) begin
            data_d       = rd_data;
            data_valid_d = 1'b1;
          end else begin
            line_d     = addr_i[ADDR_W-1:OFF_W+2];
            cnt_d      = '0;
            mem_req_d  = 1'b1;
            mem_addr_d = {addr_i[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
            state_d    = ICACHE_REFILL;
          end
        end
      end

      ICACHE_REFILL: begin
        // A fence.i during refill lets the line finish but keeps it invalid.
        if (invalidate_i) begin
          kill_d = 1'b1;
        end
        if (mem_valid_i) begin
          word_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == OFF_W'(WORDS - 1)) begin
            tag_we    = 1'b1;
            wr_valid  = !(kill_q || invalidate_i);
            mem_req_d = 1'b0;
            kill_d    = 1'b0;
            state_d   = ICACHE_IDLE;
          end else begin
            mem_addr_d = mem_addr_q + ADDR_W'(4);
          end
        end
      end

      default: state_d = ICACHE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ICACHE_IDLE;
      cnt_q        <= '0;
      kill_q       <= 1'b0;
      line_q       <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      kill_q       <= kill_d;
      line_q       <= line_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = data_valid_q;
  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed self-checking bench for the icache.
// Inputs change 1 time unit after a rising edge; outputs are checked at
// the same point, i.e. they show the effect of the edge just taken.
module tb_icache;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [31:0] addr;
  logic        wen;
  logic        inval;
  logic [31:0] data_o;
  logic        data_valid_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_valid;
  logic [31:0] mem_data;

  int checks;
  int errors;

  logic [3:0][31:0] cold_w;
  logic [3:0][31:0] conf_w;
  logic [3:0][31:0] inv_w;
  logic [3:0][31:0] stall_w;
  logic [3:0][31:0] rst_w;

  icache dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .addr_i       (addr),
    .wen_i        (wen),
    .invalidate_i (inval),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_valid_i  (mem_valid),
    .mem_data_i   (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Acts as the backing memory for one line: optional per-beat delay,
  // optional invalidate pulse on a chosen beat, checking request stability.
  task automatic do_refill(input logic [31:0] base, input logic [3:0][31:0] w,
                           input int delay, input int inval_beat);
    for (int b = 0; b < 4; b++) begin
      for (int d = 0; d < delay; d++) begin
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== base + 32'(4 * b) || data_valid_o !== 1'b0) begin
          errors++;
          $display("[TB] FAIL refill_stall beat %0d: req %b addr %h dv %b, need req 1 addr %h dv 0",
                   b, mem_req_o, mem_addr_o, data_valid_o, base + 32'(4 * b));
        end
        cycle();
      end
      checks++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== base + 32'(4 * b)) begin
        errors++;
        $display("[TB] FAIL refill_beat %0d: req %b addr %h, need req 1 addr %h",
                 b, mem_req_o, mem_addr_o, base + 32'(4 * b));
      end
      mem_valid = 1'b1;
      mem_data  = w[b];
      inval     = (b == inval_beat);
      cycle();
      mem_valid = 1'b0;
      mem_data  = '0;
      inval     = 1'b0;
    end
    checks++;
    if (mem_req_o !== 1'b0 || data_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL refill_end: req %b dv %b, need req 0 dv 0", mem_req_o, data_valid_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; addr = '0; wen = 1'b0; inval = 1'b0;
    mem_valid = 1'b0; mem_data = '0;
    repeat (3) cycle();
    checks++;
    if (data_valid_o !== 1'b0 || mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || data_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: dv %b req %b addr %h data %h, need all zero",
               data_valid_o, mem_req_o, mem_addr_o, data_o);
    end
    rst = 1'b1;
    cycle();
  endtask

  task automatic test_cold_miss();
    req_valid = 1'b1; addr = 32'h8000_0000;
    cycle();
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h8000_0000 || data_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cold_issue: req %b addr %h dv %b, need 1 80000000 0",
               mem_req_o, mem_addr_o, data_valid_o);
    end
    do_refill(32'h8000_0000, cold_w, 0, -1);
    cycle();
    checks++;
    if (data_valid_o !== 1'b1 || data_o !== 32'h0000_0013) begin
      errors++;
      $display("[TB] FAIL cold_result: dv %b data %h, need 1 00000013", data_valid_o, data_o);
    end
  endtask

  task automatic test_back_to_back();
    addr = 32'h8000_0004;
    cycle();
    checks++;
    if (data_valid_o !== 1'b1 || data_o !== 32'h0010_0093 || mem_req_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hit_0x4: dv %b data %h req %b, need 1 00100093 0",
               data_valid_o, data_o, mem_req_o);
    end
    addr = 32'h8000_000C;
    cycle();
    checks++;
    if (data_valid_o !== 1'b1 || data_o !== 32'h0030_0193 || mem_req_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hit_0xC: dv %b data %h req %b, need 1 00300193 0",
               data_valid_o, data_o, mem_req_o);
    end
    req_valid = 1'b0;
    cycle();
    checks++;
    if (data_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_no_valid: dv %b, need 0", data_valid_o);
    end
  endtask

  task automatic test_conflict();
    req_valid = 1'b1; addr = 32'h8000_0100;
    cycle();
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h8000_0100 || data_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL conflict_issue: req %b addr %h dv %b, need 1 80000100 0",
               mem_req_o, mem_addr_o, data_valid_o);
    end
    do_refill(32'h8000_0100, conf_w, 0, -1);
    cycle();
    checks++;
    if (data_valid_o !== 1'b1 || data_o !== 32'hAAAA_0000) begin
      errors++;
      $display("[TB] FAIL conflict_result: dv %b data %h, need 1 aaaa0000", data_valid_o, data_o);
    end
    addr = 32'h8000_0000;
    cycle();
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h8000_0000 || data_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL conflict_evict: req %b addr %h dv %b, need 1 80000000 0",
               mem_req_o, mem_addr_o, data_valid_o);
    end
    do_refill(32'h8000_0000, cold_w, 0, -1);
    cycle();
    checks++;
    if (data_valid_o !== 1'b1 || data_o !== 32'h0000_0013) begin
      errors++;
      $display("[TB] FAIL conflict_refetch: dv %b data %h, need 1 00000013", data_valid_o, data_o);
    end
    req_valid = 1'b0;
    cycle();
  endtask

  task automatic test_invalidate();
    req_valid = 1'b1; addr = 32'h8000_0020;
    cycle();
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h8000_0020) begin
      errors++;
      $display("[TB] FAIL inval_issue: req %b addr %h, need 1 80000020", mem_req_o, mem_addr_o);
    end
    do_refill(32'h8000_0020, inv_w, 0, 1);
    cycle();
    checks++;
    if (data_valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h8000_0020) begin
      errors++;
      $display("[TB] FAIL inval_killed_line: dv %b req %b addr %h, need 0 1 80000020",
               data_valid_o, mem_req_o, mem_addr_o);
    end
    do_refill(32'h8000_0020, inv_w, 0, -1);
    cycle();
    checks++;
    if (data_valid_o !== 1'b1 || data_o !== 32'h1111_0000) begin
      errors++;
      $display("[TB] FAIL inval_refetch: dv %b data %h, need 1 11110000", data_valid_o, data_o);
    end
    // Hit together with fence.i: lookup uses the pre-clear state.
    addr = 32'h8000_0024; inval = 1'b1;
    cycle();
    inval = 1'b0;
    checks++;
    if (data_valid_o !== 1'b1 || data_o !== 32'h1111_0001) begin
      errors++;
      $display("[TB] FAIL inval_same_cycle_hit: dv %b data %h, need 1 11110001", data_valid_o, data_o);
    end
    cycle();
    checks++;
    if (data_valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h8000_0020) begin
      errors++;
      $display("[TB] FAIL inval_warm_miss: dv %b req %b addr %h, need 0 1 80000020",
               data_valid_o, mem_req_o, mem_addr_o);
    end
    do_refill(32'h8000_0020, inv_w, 0, -1);
    cycle();
    checks++;
    if (data_valid_o !== 1'b1 || data_o !== 32'h1111_0001) begin
      errors++;
      $display("[TB] FAIL inval_final: dv %b data %h, need 1 11110001", data_valid_o, data_o);
    end
    req_valid = 1'b0;
    cycle();
  endtask

  task automatic test_stall();
    req_valid = 1'b1; addr = 32'h8000_0040;
    cycle();
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h8000_0040) begin
      errors++;
      $display("[TB] FAIL stall_issue: req %b addr %h, need 1 80000040", mem_req_o, mem_addr_o);
    end
    do_refill(32'h8000_0040, stall_w, 5, -1);
    cycle();
    checks++;
    if (data_valid_o !== 1'b1 || data_o !== 32'h4444_0000) begin
      errors++;
      $display("[TB] FAIL stall_result: dv %b data %h, need 1 44440000", data_valid_o, data_o);
    end
    req_valid = 1'b0;
    cycle();
  endtask

  task automatic test_idle_mem_valid();
    mem_valid = 1'b1; mem_data = 32'hDEAD_BEEF;
    cycle();
    mem_valid = 1'b0; mem_data = '0;
    checks++;
    if (mem_req_o !== 1'b0 || data_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_mem_valid: req %b dv %b, need 0 0", mem_req_o, data_valid_o);
    end
    req_valid = 1'b1; addr = 32'h8000_0044;
    cycle();
    checks++;
    if (data_valid_o !== 1'b1 || data_o !== 32'h4444_0001) begin
      errors++;
      $display("[TB] FAIL idle_mem_valid_hit: dv %b data %h, need 1 44440001", data_valid_o, data_o);
    end
    req_valid = 1'b0;
    cycle();
  endtask

  task automatic test_write_drop();
    req_valid = 1'b1; wen = 1'b1; addr = 32'h8000_0080;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (data_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wen_miss_dropped %0d: dv %b req %b, need 0 0", i, data_valid_o, mem_req_o);
      end
    end
    addr = 32'h8000_0044;
    cycle();
    checks++;
    if (data_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wen_hit_dropped: dv %b req %b, need 0 0", data_valid_o, mem_req_o);
    end
    wen = 1'b0; req_valid = 1'b0;
    cycle();
  endtask

  task automatic test_reset_mid_refill();
    req_valid = 1'b1; addr = 32'h8000_0060;
    cycle();
    mem_valid = 1'b1; mem_data = 32'h6666_FFFF;
    cycle();
    mem_valid = 1'b0; mem_data = '0;
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h8000_0064) begin
      errors++;
      $display("[TB] FAIL rst_pre_beat1: req %b addr %h, need 1 80000064", mem_req_o, mem_addr_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || data_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_async_drop: req %b addr %h dv %b, need 0 0 0",
               mem_req_o, mem_addr_o, data_valid_o);
    end
    cycle();
    rst = 1'b1;
    cycle();
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h8000_0060 || data_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_remiss: req %b addr %h dv %b, need 1 80000060 0",
               mem_req_o, mem_addr_o, data_valid_o);
    end
    do_refill(32'h8000_0060, rst_w, 0, -1);
    cycle();
    checks++;
    if (data_valid_o !== 1'b1 || data_o !== 32'h6666_0000) begin
      errors++;
      $display("[TB] FAIL rst_refill_result: dv %b data %h, need 1 66660000", data_valid_o, data_o);
    end
    // A line filled before the reset must not survive it.
    addr = 32'h8000_0044;
    cycle();
    checks++;
    if (data_valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h8000_0040) begin
      errors++;
      $display("[TB] FAIL rst_cleared_line: dv %b req %b addr %h, need 0 1 80000040",
               data_valid_o, mem_req_o, mem_addr_o);
    end
    do_refill(32'h8000_0040, stall_w, 0, -1);
    cycle();
    checks++;
    if (data_valid_o !== 1'b1 || data_o !== 32'h4444_0001) begin
      errors++;
      $display("[TB] FAIL rst_cleared_refetch: dv %b data %h, need 1 44440001", data_valid_o, data_o);
    end
    req_valid = 1'b0;
    cycle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    cold_w  = {32'h0030_0193, 32'h0020_0113, 32'h0010_0093, 32'h0000_0013};
    conf_w  = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
    inv_w   = {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000};
    stall_w = {32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000};
    rst_w   = {32'h6666_0003, 32'h6666_0002, 32'h6666_0001, 32'h6666_0000};

    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_invalidate();
    test_stall();
    test_idle_mem_valid();
    test_write_drop();
    test_reset_mid_refill();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
